// File: rtl/nh_lcd_pixel_feeder.sv
// Packs a 24-bit RGB valid/ready stream into ping-pong FIFO buffers, tagging end-of-line in bit 24.
// Optional on-chip stripe generator: define NH_LCD_FEEDER_TEST_PATTERN_EN.
module nh_lcd_pixel_feeder #(
  parameter int FIFO_DATA_WIDTH = 25,
  parameter int POS_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_enable,
  input  logic [31:0]                i_image_width,
  input  logic [31:0]                i_image_height,
  input  logic                       i_pix_valid,
  output logic                       o_pix_ready,
  input  logic [23:0]                i_pix_data,
  input  logic                       i_pix_last,
  input  logic [1:0]                 i_fifo_rdy,
  output logic [1:0]                 o_fifo_act,
  input  logic [23:0]                i_fifo_size,
  output logic                       o_fifo_stb,
  output logic [FIFO_DATA_WIDTH-1:0] o_fifo_data,
  output logic                       o_frame_done,
  output logic                       o_line_err,
  output logic                       o_busy
`ifdef NH_LCD_FEEDER_TEST_PATTERN_EN
  ,
  input  logic                       i_tp_en,
  input  logic                       i_tp_red,
  input  logic                       i_tp_green,
  input  logic                       i_tp_blue
`endif
);

  // Handshake: a pixel moves on a rising edge where i_pix_valid && o_pix_ready.
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RELEASE} state_t;

  state_t               state;
  logic [POS_WIDTH-1:0] x;
  logic [POS_WIDTH-1:0] y;
  logic [POS_WIDTH-1:0] width_l;
  logic [POS_WIDTH-1:0] height_l;
  logic [23:0]          r_count;
  logic [23:0]          r_next;
  logic                 space;
  logic                 xfer;
  logic                 eol;
  logic                 last_line;
  logic                 full;
  logic                 frame_start;
  logic                 start_ok;
  logic                 line_bad;
  logic [23:0]          pix;

  assign space       = (state == S_WRITE) && (r_count < i_fifo_size);
  assign eol         = (x == width_l - 1'b1);
  assign last_line   = (y == height_l - 1'b1);
  assign r_next      = r_count + 24'd1;
  assign full        = (r_next == i_fifo_size);
  assign frame_start = (x == '0) && (y == '0);
  // Geometry only matters when it is about to be latched; mid-frame the latched copy rules.
  assign start_ok    = i_enable && (i_fifo_rdy != 2'b00) && (o_fifo_act == 2'b00) &&
                       (!frame_start || ((i_image_width != 32'd0) && (i_image_height != 32'd0)));

`ifdef NH_LCD_FEEDER_TEST_PATTERN_EN
  logic tp_mode;
  assign o_pix_ready = space && !tp_mode;
  assign xfer        = tp_mode ? space : (space && i_pix_valid);
  assign pix         = tp_mode ? {i_tp_red   ? 8'hFF : 8'h00,
                                  i_tp_green ? 8'hFF : 8'h00,
                                  i_tp_blue  ? 7'h7F : 7'h00, i_tp_blue ^ x[3]}
                               : i_pix_data;
  assign line_bad    = !tp_mode && (i_pix_last != eol);
`else
  assign o_pix_ready = space;
  assign xfer        = space && i_pix_valid;
  assign pix         = i_pix_data;
  assign line_bad    = (i_pix_last != eol);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      x            <= '0;
      y            <= '0;
      width_l      <= '0;
      height_l     <= '0;
      r_count      <= '0;
      o_fifo_act   <= 2'b00;
      o_fifo_stb   <= 1'b0;
      o_fifo_data  <= '0;
      o_frame_done <= 1'b0;
      o_line_err   <= 1'b0;
      o_busy       <= 1'b0;
`ifdef NH_LCD_FEEDER_TEST_PATTERN_EN
      tp_mode      <= 1'b0;
`endif
    end else begin
      o_fifo_stb   <= 1'b0;
      o_frame_done <= 1'b0;
      o_line_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!i_enable) begin
            x <= '0;
            y <= '0;
          end else if (start_ok) begin
            o_fifo_act <= i_fifo_rdy[0] ? 2'b01 : 2'b10;
            r_count    <= '0;
            o_busy     <= 1'b1;
            state      <= S_WRITE;
            if (frame_start) begin
              width_l  <= POS_WIDTH'(i_image_width);
              height_l <= POS_WIDTH'(i_image_height);
`ifdef NH_LCD_FEEDER_TEST_PATTERN_EN
              tp_mode  <= i_tp_en;
`endif
            end
          end
        end
        S_WRITE: begin
          if (xfer) begin
            o_fifo_stb  <= 1'b1;
            o_fifo_data <= FIFO_DATA_WIDTH'({eol, pix});
            o_line_err  <= line_bad;
            r_count     <= r_next;
            if (eol) begin
              x <= '0;
              if (last_line) begin
                y            <= '0;
                o_frame_done <= 1'b1;
              end else begin
                y <= y + 1'b1;
              end
            end else begin
              x <= x + 1'b1;
            end
            if (eol || full) state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // The last strobe is on the bus now; ownership drops one cycle later.
          o_fifo_act <= 2'b00;
          o_busy     <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nh_lcd_pixel_feeder.sv
// Bench for nh_lcd_pixel_feeder: cycle table for a 4x2 frame plus hand sequences for buffer, reset and error corners.
module tb_nh_lcd_pixel_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] image_width;
  logic [31:0] image_height;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_data;
  logic        pix_last;
  logic [1:0]  fifo_rdy;
  logic [1:0]  fifo_act;
  logic [23:0] fifo_size;
  logic        fifo_stb;
  logic [24:0] fifo_data;
  logic        frame_done;
  logic        line_err;
  logic        busy;
`ifdef NH_LCD_FEEDER_TEST_PATTERN_EN
  logic        tp_en, tp_red, tp_green, tp_blue;
`endif

  always #5 clk = ~clk;

  nh_lcd_pixel_feeder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_enable       (enable),
    .i_image_width  (image_width),
    .i_image_height (image_height),
    .i_pix_valid    (pix_valid),
    .o_pix_ready    (pix_ready),
    .i_pix_data     (pix_data),
    .i_pix_last     (pix_last),
    .i_fifo_rdy     (fifo_rdy),
    .o_fifo_act     (fifo_act),
    .i_fifo_size    (fifo_size),
    .o_fifo_stb     (fifo_stb),
    .o_fifo_data    (fifo_data),
    .o_frame_done   (frame_done),
    .o_line_err     (line_err),
    .o_busy         (busy)
`ifdef NH_LCD_FEEDER_TEST_PATTERN_EN
    ,
    .i_tp_en        (tp_en),
    .i_tp_red       (tp_red),
    .i_tp_green     (tp_green),
    .i_tp_blue      (tp_blue)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard state collected by the monitor
  logic [24:0] got_q[$];
  logic [24:0] exp_q[$];
  int buf_q[$];
  int act_q[$];
  int done_q[$];
  int err_q[$];
  int nwords, inbuf, act_bad, stray;
  logic [1:0] prev_act;

  initial begin
    nwords = 0; inbuf = 0; act_bad = 0; stray = 0; prev_act = 2'b00;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_act = 2'b00;
      inbuf    = 0;
    end else begin
      if (fifo_stb) begin
        got_q.push_back(fifo_data);
        if (frame_done) done_q.push_back(nwords);
        if (line_err) err_q.push_back(nwords);
        nwords++;
        inbuf++;
      end else if (frame_done || line_err) begin
        stray++;
      end
      if (fifo_act == 2'b11) act_bad++;
      if (fifo_act != 2'b00 && prev_act == 2'b00) act_q.push_back(int'(fifo_act));
      if (fifo_act == 2'b00 && prev_act != 2'b00) begin
        buf_q.push_back(inbuf);
        inbuf = 0;
      end
      prev_act = fifo_act;
    end
  end

  task automatic clear_mon();
    got_q.delete(); exp_q.delete(); buf_q.delete(); act_q.delete();
    done_q.delete(); err_q.delete();
    nwords = 0;
    inbuf  = 0;
  endtask

  task automatic chk_words(input string tag);
    chk({tag, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // Called right after a falling edge; returns on the falling edge after the pixel was taken.
  task automatic send_pix(input logic [23:0] d, input logic l);
    int n;
    n = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = l;
    #1;
    while (!pix_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("send_ready", 32'(pix_ready), 32'd1);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [23:0] dk(input int k);
    return 24'hA00000 + 24'(k);
  endfunction

  typedef struct {
    logic        en;
    logic        valid;
    logic [23:0] data;
    logic        last;
    logic        exp_ready;
    logic        exp_stb;
    logic [24:0] exp_data;
    logic [1:0]  exp_act;
    logic        exp_done;
    logic        exp_busy;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic valid, input logic [23:0] data,
                              input logic last, input logic rdy, input logic stb,
                              input logic [24:0] d, input logic [1:0] act,
                              input logic done, input logic bsy);
    vec_t v;
    v.en = en; v.valid = valid; v.data = data; v.last = last;
    v.exp_ready = rdy; v.exp_stb = stb; v.exp_data = d; v.exp_act = act;
    v.exp_done = done; v.exp_busy = bsy;
    return v;
  endfunction

  vec_t vecs[14];

  initial begin
    rst_n = 1'b0; enable = 1'b0; image_width = 32'd4; image_height = 32'd2;
    pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0; fifo_rdy = 2'b01; fifo_size = 24'd16;
`ifdef NH_LCD_FEEDER_TEST_PATTERN_EN
    tp_en = 1'b0; tp_red = 1'b0; tp_green = 1'b0; tp_blue = 1'b0;
`endif

    // 4x2 frame, one buffer per line, continuous valid
    vecs[0]  = mk(1, 1, dk(0), 0, 0, 0, 25'h0,            2'b00, 0, 0);
    vecs[1]  = mk(1, 1, dk(0), 0, 1, 0, 25'h0,            2'b01, 0, 1);
    vecs[2]  = mk(1, 1, dk(1), 0, 1, 1, {1'b0, dk(0)},    2'b01, 0, 1);
    vecs[3]  = mk(1, 1, dk(2), 0, 1, 1, {1'b0, dk(1)},    2'b01, 0, 1);
    vecs[4]  = mk(1, 1, dk(3), 1, 1, 1, {1'b0, dk(2)},    2'b01, 0, 1);
    vecs[5]  = mk(1, 1, dk(4), 0, 0, 1, {1'b1, dk(3)},    2'b01, 0, 1);
    vecs[6]  = mk(1, 1, dk(4), 0, 0, 0, 25'h0,            2'b00, 0, 0);
    vecs[7]  = mk(1, 1, dk(4), 0, 1, 0, 25'h0,            2'b01, 0, 1);
    vecs[8]  = mk(1, 1, dk(5), 0, 1, 1, {1'b0, dk(4)},    2'b01, 0, 1);
    vecs[9]  = mk(1, 1, dk(6), 0, 1, 1, {1'b0, dk(5)},    2'b01, 0, 1);
    vecs[10] = mk(1, 1, dk(7), 1, 1, 1, {1'b0, dk(6)},    2'b01, 0, 1);
    vecs[11] = mk(0, 0, dk(0), 0, 0, 1, {1'b1, dk(7)},    2'b01, 1, 1);
    vecs[12] = mk(0, 0, dk(0), 0, 0, 0, 25'h0,            2'b00, 0, 0);
    vecs[13] = mk(0, 0, dk(0), 0, 0, 0, 25'h0,            2'b00, 0, 0);

    idle(2);
    #1;
    chk("rst_stb",  32'(fifo_stb),  32'd0);
    chk("rst_data", 32'(fifo_data), 32'd0);
    chk("rst_act",  32'(fifo_act),  32'd0);
    chk("rst_busy", 32'(busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      enable = vecs[i].en; pix_valid = vecs[i].valid;
      pix_data = vecs[i].data; pix_last = vecs[i].last;
      #1;
      chk($sformatf("t%0d_ready", i), 32'(pix_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("t%0d_stb", i),   32'(fifo_stb),  32'(vecs[i].exp_stb));
      if (vecs[i].exp_stb) chk($sformatf("t%0d_data", i), 32'(fifo_data), 32'(vecs[i].exp_data));
      chk($sformatf("t%0d_act", i),   32'(fifo_act),  32'(vecs[i].exp_act));
      chk($sformatf("t%0d_done", i),  32'(frame_done), 32'(vecs[i].exp_done));
      chk($sformatf("t%0d_err", i),   32'(line_err),  32'd0);
      chk($sformatf("t%0d_busy", i),  32'(busy),      32'(vecs[i].exp_busy));
    end

    // Width 10 with 4-word buffers: 4 + 4 + 2, eol only on the 10th word
    @(negedge clk);
    clear_mon();
    image_width = 32'd10; image_height = 32'd1; fifo_size = 24'd4; fifo_rdy = 2'b01; enable = 1'b1;
    for (int k = 0; k < 10; k++) send_pix(24'(k), k == 9);
    enable = 1'b0;
    idle(4);
    for (int k = 0; k < 10; k++) exp_q.push_back({k == 9, 24'(k)});
    chk_words("w10");
    chk("w10_nbuf", 32'(buf_q.size()), 32'd3);
    chk("w10_buf0", 32'(buf_q[0]), 32'd4);
    chk("w10_buf1", 32'(buf_q[1]), 32'd4);
    chk("w10_buf2", 32'(buf_q[2]), 32'd2);
    chk("w10_ndone", 32'(done_q.size()), 32'd1);
    chk("w10_done_at", 32'(done_q[0]), 32'd9);
    chk("w10_nerr", 32'(err_q.size()), 32'd0);

    // Both buffers ready picks buffer 0, then only buffer 1 is ready
    clear_mon();
    image_width = 32'd2; image_height = 32'd2; fifo_size = 24'd16; fifo_rdy = 2'b11; enable = 1'b1;
    send_pix(24'h111111, 1'b0);
    send_pix(24'h222222, 1'b1);
    fifo_rdy = 2'b10;
    send_pix(24'h333333, 1'b0);
    send_pix(24'h444444, 1'b1);
    enable = 1'b0;
    idle(4);
    exp_q.push_back({1'b0, 24'h111111}); exp_q.push_back({1'b1, 24'h222222});
    exp_q.push_back({1'b0, 24'h333333}); exp_q.push_back({1'b1, 24'h444444});
    chk_words("pp");
    chk("pp_nact", 32'(act_q.size()), 32'd2);
    chk("pp_act0", 32'(act_q[0]), 32'd1);
    chk("pp_act1", 32'(act_q[1]), 32'd2);
    chk("pp_done_at", 32'(done_q[0]), 32'd3);

    // Source last one pixel early: error on both the early and the real end of line
    clear_mon();
    image_width = 32'd4; image_height = 32'd1; fifo_rdy = 2'b01; enable = 1'b1;
    send_pix(24'h000010, 1'b0);
    send_pix(24'h000011, 1'b0);
    send_pix(24'h000012, 1'b1);
    send_pix(24'h000013, 1'b0);
    enable = 1'b0;
    idle(4);
    exp_q.push_back({1'b0, 24'h000010}); exp_q.push_back({1'b0, 24'h000011});
    exp_q.push_back({1'b0, 24'h000012}); exp_q.push_back({1'b1, 24'h000013});
    chk_words("le");
    chk("le_nerr", 32'(err_q.size()), 32'd2);
    chk("le_err0", 32'(err_q[0]), 32'd2);
    chk("le_err1", 32'(err_q[1]), 32'd3);

    // Asynchronous reset while the third pixel is offered, then a clean restart
    clear_mon();
    enable = 1'b1;
    send_pix(24'h000020, 1'b0);
    send_pix(24'h000021, 1'b0);
    pix_valid = 1'b1; pix_data = 24'h000022; pix_last = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ready", 32'(pix_ready),  32'd0);
    chk("ar_stb",   32'(fifo_stb),   32'd0);
    chk("ar_data",  32'(fifo_data),  32'd0);
    chk("ar_act",   32'(fifo_act),   32'd0);
    chk("ar_done",  32'(frame_done), 32'd0);
    chk("ar_err",   32'(line_err),   32'd0);
    chk("ar_busy",  32'(busy),       32'd0);
    pix_valid = 1'b0;
    clear_mon();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) send_pix(24'h000030 + 24'(k), k == 3);
    enable = 1'b0;
    idle(4);
    for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, 24'h000030 + 24'(k)});
    chk_words("rs");
    chk("rs_done_at", 32'(done_q[0]), 32'd3);
    chk("rs_nerr", 32'(err_q.size()), 32'd0);

    // Zero-size buffer holds WRITE with ready low; a full-and-eol transfer releases once
    clear_mon();
    image_width = 32'd2; image_height = 32'd1; fifo_size = 24'd0; enable = 1'b1;
    pix_valid = 1'b1; pix_data = 24'h000040; pix_last = 1'b0;
    idle(3);
    #1;
    chk("z_ready", 32'(pix_ready), 32'd0);
    chk("z_act",   32'(fifo_act),  32'd1);
    chk("z_busy",  32'(busy),      32'd1);
    chk("z_nwords", 32'(nwords),   32'd0);
    @(negedge clk);
    fifo_size = 24'd2;
    send_pix(24'h000040, 1'b0);
    send_pix(24'h000041, 1'b1);
    enable = 1'b0;
    idle(4);
    exp_q.push_back({1'b0, 24'h000040}); exp_q.push_back({1'b1, 24'h000041});
    chk_words("z");
    chk("z_nbuf", 32'(buf_q.size()), 32'd1);
    chk("z_buf0", 32'(buf_q[0]), 32'd2);

`ifdef NH_LCD_FEEDER_TEST_PATTERN_EN
    // Red stripes: blue LSB follows x[3]; stream port stays closed
    begin
      int n;
      int ready_seen;
      clear_mon();
      image_width = 32'd16; image_height = 32'd1; fifo_size = 24'd16;
      tp_en = 1'b1; tp_red = 1'b1; enable = 1'b1;
      n = 0;
      ready_seen = 0;
      while (got_q.size() < 16 && n < 60) begin
        @(negedge clk);
        #1;
        if (pix_ready) ready_seen++;
        n++;
      end
      enable = 1'b0;
      idle(4);
      tp_en = 1'b0;
      tp_red = 1'b0;
      for (int k = 0; k < 16; k++) exp_q.push_back({k == 15, 16'hFF00, 7'h00, k >= 8});
      chk_words("tp");
      chk("tp_ready_seen", 32'(ready_seen), 32'd0);
      chk("tp_nerr", 32'(err_q.size()), 32'd0);
    end
`endif

    chk("act_never_11", 32'(act_bad), 32'd0);
    chk("stray_pulses", 32'(stray), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
